// File: rtl/chord_fifo_pkg.sv
// rtl/chord_fifo_pkg.sv - shared widths, limits and occupancy-step helper for the CHORD FIFO write arbiter
package chord_fifo_pkg;

   localparam int CHORD_DATA_W     = 32;
   localparam int CHORD_FIFO_DEPTH = 16;
   localparam int CHORD_LEVEL_W    = $clog2(CHORD_FIFO_DEPTH) + 1;
   localparam int STAT_W           = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      OCC_HOLD = 2'd0,
      OCC_INC  = 2'd1,
      OCC_DEC  = 2'd2
   } occ_op_e;

   // A same-cycle accept and pop cancel out.
   function automatic occ_op_e occ_op(input logic acc, input logic pop);
      if (acc && !pop) return OCC_INC;
      if (pop && !acc) return OCC_DEC;
      return OCC_HOLD;
   endfunction

endpackage

// File: rtl/chord_fifo_wr_arb_if.sv
// rtl/chord_fifo_wr_arb_if.sv - producer/FIFO-side bundle of the CHORD write arbiter
interface chord_fifo_wr_arb_if
   import chord_fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = CHORD_DATA_W,
   parameter int DEPTH   = CHORD_FIFO_DEPTH
);
   localparam int LEVEL_W = $clog2(DEPTH) + 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic                      fifo_wr_en;
   logic [DATA_W-1:0]         fifo_wr_data;
   logic                      fifo_rd_en;
   logic                      fifo_empty;
   logic [LEVEL_W-1:0]        level;
   logic                      full;
   logic                      uflow_err;
   logic [NUM_REQ*STAT_W-1:0] stat_cnt;

   modport master (
      output req, req_data, fifo_rd_en, fifo_empty,
      input  gnt, fifo_wr_en, fifo_wr_data, level, full, uflow_err, stat_cnt
   );

   modport slave (
      input  req, req_data, fifo_rd_en, fifo_empty,
      output gnt, fifo_wr_en, fifo_wr_data, level, full, uflow_err, stat_cnt
   );

endinterface

// File: rtl/chord_rr_pick.sv
// rtl/chord_rr_pick.sv - combinational round-robin picker: rotate by rr_ptr, take lowest set bit, rotate back
module chord_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] gnt
);

   logic [NUM_REQ-1:0] rot;
   logic [NUM_REQ-1:0] rot_gnt;
   logic [NUM_REQ-1:0] unrot;

   always_comb begin
      rot     = NUM_REQ'({req, req} >> rr_ptr);
      // Two's-complement trick isolates the lowest set bit.
      rot_gnt = rot & (~rot + NUM_REQ'(1));
      unrot   = NUM_REQ'({rot_gnt, rot_gnt} >> (NUM_REQ - int'(rr_ptr)));
      gnt     = enable ? unrot : '0;
   end

endmodule

// File: rtl/chord_fifo_wr_arb.sv
// rtl/chord_fifo_wr_arb.sv - round-robin write arbiter and occupancy tracker for the CHORD event FIFO
// Define CHORD_ARB_STATS_EN to build the per-producer saturating accepted-word counters.
module chord_fifo_wr_arb
   import chord_fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = CHORD_DATA_W,
   parameter int DEPTH   = CHORD_FIFO_DEPTH
) (
   input logic                clk,
   input logic                reset,
   chord_fifo_wr_arb_if.slave bus
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int LEVEL_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_nxt;
   logic [NUM_REQ-1:0] gnt;
   logic [DATA_W-1:0]  win_data;
   logic               acc;
   logic               pop;
   logic               full;
   logic [LEVEL_W-1:0] level;
   logic               wr_en;
   logic [DATA_W-1:0]  wr_data;
   logic               uflow_err;

   assign full = (level == LEVEL_W'(DEPTH));

   // Grants are also held off while reset is asserted so gnt reads 0 in reset.
   chord_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .enable (reset & ~full),
      .gnt    (gnt)
   );

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      win_data   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            rr_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            win_data   = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign acc = |(bus.req & gnt);
   assign pop = bus.fifo_rd_en & ~bus.fifo_empty;

   // Level counts a word from its accept cycle, covering the one-cycle write flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
         level     <= '0;
         uflow_err <= 1'b0;
      end else begin
         wr_en <= acc;
         if (acc) begin
            rr_ptr  <= rr_ptr_nxt;
            wr_data <= win_data;
         end
         if (pop && level == '0) begin
            uflow_err <= 1'b1;
         end
         case (occ_op(acc, pop))
            OCC_INC: level <= level + LEVEL_W'(1);
            OCC_DEC: if (level != '0) level <= level - LEVEL_W'(1);
            default: ;
         endcase
      end
   end

`ifdef CHORD_ARB_STATS_EN
   logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && gnt[i] && stat_q[i] != STAT_MAX) begin
               stat_q[i] <= stat_q[i] + STAT_W'(1);
            end
         end
      end
   end

   assign bus.stat_cnt = stat_q;
`else
   assign bus.stat_cnt = '0;
`endif

   assign bus.gnt          = gnt;
   assign bus.fifo_wr_en   = wr_en;
   assign bus.fifo_wr_data = wr_data;
   assign bus.level        = level;
   assign bus.full         = full;
   assign bus.uflow_err    = uflow_err;

endmodule

// File: doc/chord_fifo_wr_arb.md
Name: chord_fifo_wr_arb

Overview:
- Round-robin write arbiter and occupancy controller in front of the CHORD 16-deep x 32-bit event FIFO.
- Shares the single FIFO write port between NUM_REQ producers, e.g. the key-scan interface and the timer/status word source.
- The FIFO has no full flag, so this block tracks occupancy, withholds grants at capacity, and registers the winning word onto the FIFO write port.

Parameters:
- NUM_REQ, 4: number of producers, minimum 2.
- DATA_W, 32: word width; must equal the FIFO width.
- DEPTH, 16: FIFO depth; must equal the FIFO capacity.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; shared with the FIFO.
- req  in  NUM_REQ  per-producer word-valid.
- req_data  in  NUM_REQ*DATA_W  producer words; producer i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot combinational accept; a word is accepted when req[i]&gnt[i].
- fifo_wr_en  out  1  drives the FIFO valid_out_interface.
- fifo_wr_data  out  DATA_W  drives the FIFO out_interface.
- fifo_rd_en  in  1  copy of the consumer's FIFO read enable.
- fifo_empty  in  1  FIFO empty flag.
- level  out  $clog2(DEPTH)+1  reserved occupancy, 0..DEPTH.
- full  out  1  high when level==DEPTH.
- uflow_err  out  1  sticky: a pop was seen while level==0.
- stat_cnt  out  NUM_REQ*16  per-producer accepted-word counters; see Optional Feature.

Behaviour:
- Reset values: gnt=0, fifo_wr_en=0, fifo_wr_data=0, level=0, full=0, uflow_err=0, rr_ptr=0, stat_cnt=0.
- Grant (combinational):
  - If full or req==0, then gnt=0.
  - Otherwise grant the first requester with req set, scanning from rr_ptr upward modulo NUM_REQ.
  - At most one grant per cycle.
- rr_ptr: after a grant to i, rr_ptr <= (i+1) mod NUM_REQ. It holds on idle cycles.
- Write path latency is 1 cycle:
  - On accept, the next cycle has fifo_wr_en=1 and fifo_wr_data=req_data[i].
  - With no accept, fifo_wr_en=0 and fifo_wr_data holds its last value.
- Occupancy:
  - acc = |(req&gnt).
  - pop = fifo_rd_en & ~fifo_empty.
  - level increments at accept time, not at FIFO write, so the in-flight word is reserved.
  - acc&~pop: +1. pop&~acc: -1. Both or neither: unchanged.
  - full=1 when level==DEPTH.
- Full boundary:
  - With level==DEPTH and a pop in the same cycle, there is still no grant that cycle; grants resume the next cycle.
  - The FIFO wp can therefore never pass rp+DEPTH.
- Empty boundary:
  - A word accepted at cycle t is visible at the FIFO at t+2 (fifo_empty deasserts then).
  - level already counts it from t+1. The consumer never pops it early because pop is gated by fifo_empty.
- Underflow:
  - pop with level==0 sets uflow_err. It stays set until reset.
  - level stays at 0; it does not wrap.
- Producer rules:
  - req_data must be stable while req is high.
  - Dropping req without a grant is legal; no word is lost or duplicated.
- Reset mid-operation: any registered in-flight write is dropped (fifo_wr_en=0). The FIFO is cleared by the same reset, so level=0 stays consistent.

Optional Feature:
- Macro: CHORD_ARB_STATS_EN.
- Defined:
  - One 16-bit counter per producer, incremented on each accepted word.
  - Saturates at 16'hFFFF; cleared only by reset.
  - Exposed on stat_cnt.
- Undefined: no counters are built; stat_cnt is tied to 0.
- Port list is identical in both builds.

Decomposition:
- Package chord_fifo_pkg:
  - CHORD_DATA_W=32, CHORD_FIFO_DEPTH=16.
  - CHORD_LEVEL_W=$clog2(DEPTH)+1.
  - STAT_W=16, STAT_MAX=16'hFFFF.
- Sub-module chord_rr_pick:
  - Inputs: req, rr_ptr, enable.
  - Output: one-hot gnt.
  - Purely combinational, with a rotate-priority-encode-unrotate structure.
- The top holds rr_ptr, the level counter, the write register and the stats.

Test Plan:
- Reset, then req=4'b0001, data 32'hA5A5_0001, for 1 cycle -> gnt=0001 that cycle; next cycle fifo_wr_en=1, fifo_wr_data=32'hA5A5_0001; level=1.
- req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; level=8; FIFO read-back order matches the grant order.
- 16 accepts with no reads -> level=16, full=1, gnt=0 with req still high; one pop -> level=15, and gnt reasserts the following cycle.
- Simultaneous accept and pop at level=5 -> level stays 5; fifo_wr_en pulses once.
- Force fifo_rd_en=1 with fifo_empty=0 at level=0 -> uflow_err=1, level=0; uflow_err stays 1 until reset.
- Assert reset during a streaming burst at level=9 -> all outputs return to reset values immediately; with CHORD_ARB_STATS_EN, counters preset near 16'hFFFF saturate at 16'hFFFF.
